// File: rtl/count_wrap_mon_ift_pkg.sv
// Shared types, constants and helpers for count_wrap_monitor_ift.
// The taint feature is selected by COUNT_WRAP_MON_TAINT_EN.
package count_wrap_mon_ift_pkg;

  localparam int TAINT_W_DEF = 32;
  localparam int CNT_W_DEF   = 4;
  localparam int CNT_MAX     = (1 << CNT_W_DEF) - 1;

  typedef enum logic {IDLE, REPORT} mon_state_e;

  // Shadow register update modes.
  typedef enum logic [1:0] {SH_HOLD, SH_LOAD, SH_OR} sh_mode_e;

  // Saturating increment; callers cast to their own width.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/count_wrap_monitor_ift_shadow.sv
// ift_shadow_reg: taint shadow register with load / or-accumulate / hold.
// Present only when COUNT_WRAP_MON_TAINT_EN is defined.
`ifdef COUNT_WRAP_MON_TAINT_EN
module ift_shadow_reg
  import count_wrap_mon_ift_pkg::*;
#(
  parameter int TAINT_W = TAINT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [TAINT_W-1:0] rst_t,
  input  sh_mode_e           mode,
  input  logic [TAINT_W-1:0] d,
  output logic [TAINT_W-1:0] q
);

  // Reset loads the reset taint; otherwise apply the selected mode.
  always_ff @(posedge clk) begin
    if (!rst) q <= rst_t;
    else begin
      case (mode)
        SH_LOAD: q <= d;
        SH_OR:   q <= q | d;
        default: q <= q;
      endcase
    end
  end

endmodule
`endif

// File: rtl/count_wrap_monitor_ift.sv
// count_wrap_monitor_ift: counts 15->0 wraps of an upstream counter and
// raises a valid/ready event once the wrap count reaches thresh.
// Taint shadows are built only with COUNT_WRAP_MON_TAINT_EN defined.
module count_wrap_monitor_ift
  import count_wrap_mon_ift_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int WRAP_W  = 8,
  parameter int TAINT_W = TAINT_W_DEF
) (
  input  logic               clk,
  input  logic [TAINT_W-1:0] clk_t,
  input  logic               rst,
  input  logic [TAINT_W-1:0] rst_t,
  input  logic [CNT_W-1:0]   count,
  input  logic [TAINT_W-1:0] count_t,
  input  logic [WRAP_W-1:0]  thresh,
  input  logic [TAINT_W-1:0] thresh_t,
  output logic               wrap_pulse,
  output logic [TAINT_W-1:0] wrap_pulse_t,
  output logic               evt_valid,
  output logic [TAINT_W-1:0] evt_valid_t,
  output logic [WRAP_W-1:0]  evt_wraps,
  output logic [TAINT_W-1:0] evt_wraps_t,
  input  logic               evt_ready,
  input  logic [TAINT_W-1:0] evt_ready_t
);

  localparam logic [CNT_W-1:0]  CNT_TOP  = {CNT_W{1'b1}};
  localparam logic [WRAP_W-1:0] WRAP_MAX = {WRAP_W{1'b1}};
  localparam logic [WRAP_W-1:0] WRAP_ONE = {{(WRAP_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0]  prev;
  logic              prev_vld;
  logic [WRAP_W-1:0] wraps;
  logic [WRAP_W-1:0] wraps_inc;
  mon_state_e        state, state_nxt;
  logic              wrap, hs, fire;

  // An upstream reset while count==15 also looks like a wrap; that is accepted.
  assign wrap      = prev_vld && (prev == CNT_TOP) && (count == '0);
  assign hs        = (state == REPORT) && evt_valid && evt_ready;
  assign wraps_inc = WRAP_W'(sat_inc(32'(wraps), 32'(WRAP_MAX)));

  // Next state: fire on a registered compare in IDLE, leave REPORT on handshake.
  always_comb begin
    state_nxt = state;
    fire      = 1'b0;
    case (state)
      IDLE: if (thresh != '0 && wraps >= thresh) begin
        state_nxt = REPORT;
        fire      = 1'b1;
      end
      REPORT: if (hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Data path: sampling, wrap accumulation, event capture and release.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      prev       <= '0;
      prev_vld   <= 1'b0;
      wrap_pulse <= 1'b0;
      wraps      <= '0;
      evt_valid  <= 1'b0;
      evt_wraps  <= '0;
    end else begin
      state      <= state_nxt;
      prev       <= count;
      prev_vld   <= 1'b1;
      wrap_pulse <= wrap;
      // A wrap coinciding with the clear is kept as the first new wrap.
      if (hs)        wraps <= wrap ? WRAP_ONE : '0;
      else if (wrap) wraps <= wraps_inc;
      if (fire) begin
        evt_valid <= 1'b1;
        evt_wraps <= wraps;
      end else if (hs) begin
        evt_valid <= 1'b0;
      end
    end
  end

`ifdef COUNT_WRAP_MON_TAINT_EN
  logic [TAINT_W-1:0] prev_t, wraps_t, wraps_t_d, wrap_src_t;
  sh_mode_e           wraps_t_m;
  logic [TAINT_W-1:0] unused_clk_t;

  assign unused_clk_t = clk_t;
  assign wrap_src_t   = prev_t | count_t;

  // wraps_t: cleared to evt_ready_t on handshake, sticky-OR on a wrap.
  always_comb begin
    wraps_t_m = SH_HOLD;
    wraps_t_d = wrap_src_t;
    if (hs) begin
      wraps_t_m = SH_LOAD;
      wraps_t_d = evt_ready_t | (wrap ? wrap_src_t : '0);
    end else if (wrap) begin
      wraps_t_m = SH_OR;
    end
  end

  ift_shadow_reg #(.TAINT_W(TAINT_W)) u_prev_t (
    .clk(clk), .rst(rst), .rst_t(rst_t), .mode(SH_LOAD), .d(count_t), .q(prev_t));
  ift_shadow_reg #(.TAINT_W(TAINT_W)) u_wrap_pulse_t (
    .clk(clk), .rst(rst), .rst_t(rst_t), .mode(wrap ? SH_LOAD : SH_HOLD),
    .d(wrap_src_t), .q(wrap_pulse_t));
  ift_shadow_reg #(.TAINT_W(TAINT_W)) u_wraps_t (
    .clk(clk), .rst(rst), .rst_t(rst_t), .mode(wraps_t_m), .d(wraps_t_d), .q(wraps_t));
  ift_shadow_reg #(.TAINT_W(TAINT_W)) u_evt_wraps_t (
    .clk(clk), .rst(rst), .rst_t(rst_t), .mode(fire ? SH_LOAD : SH_HOLD),
    .d(wraps_t), .q(evt_wraps_t));
  ift_shadow_reg #(.TAINT_W(TAINT_W)) u_evt_valid_t (
    .clk(clk), .rst(rst), .rst_t(rst_t), .mode(fire ? SH_LOAD : SH_HOLD),
    .d(wraps_t | thresh_t), .q(evt_valid_t));
`else
  logic unused_taint;
  assign unused_taint = ^{clk_t, rst_t, count_t, thresh_t, evt_ready_t};
  assign wrap_pulse_t = '0;
  assign evt_valid_t  = '0;
  assign evt_wraps_t  = '0;
`endif

endmodule

// File: doc/count_wrap_monitor_ift.md
# count_wrap_monitor_ift

Downstream consumer of the 4-bit IFT enable counter. Watches its `count`/`count_t` outputs, detects 15→0 wrap-arounds, and accumulates a saturating wrap count. When the wrap count reaches a programmable threshold, it issues a valid/ready event. Every data signal carries a 32-bit taint shadow that is propagated with the same OR/sticky semantics the counter uses.

## Interface
Parameters:
- `CNT_W`, 4: width of observed count.
- `WRAP_W`, 8: width of wrap accumulator and threshold.
- `TAINT_W`, 32: width of every taint shadow.

Ports:
- `clk`  in  1  clock; rising-edge only.
- `clk_t`  in  TAINT_W  clock taint; accepted, not propagated.
- `rst`  in  1  reset, synchronous, active-low.
- `rst_t`  in  TAINT_W  reset taint.
- `count`  in  CNT_W  counter value from upstream.
- `count_t`  in  TAINT_W  taint of `count`.
- `thresh`  in  WRAP_W  report threshold; 0 disables reporting.
- `thresh_t`  in  TAINT_W  taint of `thresh`.
- `wrap_pulse`  out  1  one-cycle pulse per detected wrap.
- `wrap_pulse_t`  out  TAINT_W  taint of `wrap_pulse`.
- `evt_valid`  out  1  event pending.
- `evt_valid_t`  out  TAINT_W  taint of `evt_valid`.
- `evt_wraps`  out  WRAP_W  wrap count carried by the event.
- `evt_wraps_t`  out  TAINT_W  taint of `evt_wraps`.
- `evt_ready`  in  1  consumer accepts the event.
- `evt_ready_t`  in  TAINT_W  taint of `evt_ready`.

## Operation
- Reset (`rst`=0 at a rising edge):
  - All outputs go to 0; internal `prev`, `wraps` and `prev_vld` go to 0; FSM goes to IDLE.
  - Every taint register, including all output taints, loads `rst_t`.
- Sampling: each cycle `prev` <= `count` and `prev_t` <= `count_t`; `prev_vld` <= 1.
- Wrap detect: `prev_vld` && `prev`==2^CNT_W−1 && `count`==0.
  - An upstream reset issued while the count is 15 is indistinguishable from a wrap and is counted as one.
- On a wrap:
  - `wrap_pulse` <= 1.
  - `wrap_pulse_t` <= `prev_t` | `count_t`.
  - `wraps` <= min(`wraps`+1, 2^WRAP_W−1), i.e. saturating.
  - `wraps_t` <= `wraps_t` | `prev_t` | `count_t` (sticky).
- FSM states: IDLE, REPORT.
  - IDLE → REPORT when `thresh`!=0 && `wraps` >= `thresh`.
    - On entry: `evt_wraps` <= `wraps`, `evt_wraps_t` <= `wraps_t`, `evt_valid` <= 1, `evt_valid_t` <= `wraps_t` | `thresh_t`.
  - REPORT holds `evt_valid`, `evt_wraps` and their taints stable until `evt_ready`=1.
  - REPORT → IDLE on `evt_valid` && `evt_ready`:
    - `evt_valid` <= 0 and `wraps` <= 0.
    - `wraps_t` <= `evt_ready_t`; the clear is controlled by `evt_ready`.
  - Handshake in the same cycle as a wrap: `wraps` <= 1 and `wraps_t` <= `evt_ready_t` | `prev_t` | `count_t`. The wrap is never lost.
  - `thresh` changes while in REPORT are ignored until return to IDLE.
- Wraps keep accumulating (saturating) while in REPORT; `evt_wraps` is not updated.

## Timing
- Wrap detect to `wrap_pulse`: 1 cycle after the edge where `count`==0 is sampled.
- `wraps` update to `evt_valid`: 1 cycle (registered compare).
  - Minimum wrap-to-`evt_valid` latency is therefore 2 cycles.
- `evt_valid` deasserts on the cycle after the accepting edge. Back-to-back events are separated by at least 1 IDLE cycle.
- `evt_ready` may be high while `evt_valid`=0; it has no effect then.
- First cycle after reset release never reports a wrap, because `prev_vld`=0.

## Configuration
- `COUNT_WRAP_MON_TAINT_EN` defined: full taint propagation as described above.
- Undefined:
  - All `*_t` ports remain on the interface; every output taint is tied to 0.
  - All taint registers are removed.
  - Functional (non-taint) behaviour is identical.

## Structure
- Shared package `count_wrap_mon_ift_pkg`:
  - FSM state enum (IDLE, REPORT).
  - Constants `TAINT_W_DEF`=32 and `CNT_MAX` (= 2^CNT_W−1).
  - Saturating-increment function.
- One sub-module, `ift_shadow_reg`: a TAINT_W register with sync active-low reset loading `rst_t` and modes load/or-accumulate/hold. It is instantiated per taint register and compiled out with the macro.

## Test plan
- Reset with `rst_t`=0x5 → all outputs 0; all output taints = 0x5; no `wrap_pulse` on the first post-reset cycle even if `count`=0.
- `count` 14,15,0 with `count_t`=0x10 on the 0 → `wrap_pulse`=1 for one cycle; `wrap_pulse_t`=0x10; `wraps`=1.
- `thresh`=3, three wraps, `evt_ready`=0 → `evt_valid`=1 with `evt_wraps`=3, held for 5 cycles; a 4th wrap leaves `evt_wraps` at 3.
- `evt_ready`=1 in the same cycle as a wrap → `evt_valid` drops; internal `wraps`=1; next event needs only 2 more wraps at `thresh`=3.
- `thresh`=0, 300 wraps → no `evt_valid`; `wraps` saturates at 255; then `thresh`=255 → event with `evt_wraps`=255.
- Macro undefined, nonzero `count_t`/`rst_t` → all output taints 0; data outputs match the taint-enabled run cycle for cycle.
